// File: rtl/cs_final_add.sv
// Two-stage carry-save to binary final adder with valid/ready flow control.
// Optional sticky output enabled by defining CS_FINAL_ADD_STICKY_EN.
module cs_final_add #(
    parameter int N   = 14,
    parameter int LO  = 7,
    parameter int STK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_t,
    input  logic [N-1:0] in_s,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N:0]   out_sum,
    output logic         out_sticky,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int HW = N - LO;

    logic [LO-1:0] lo_sum_q, lo_sum_d;
    logic          c1_q, c1_d;
    logic [HW-1:0] t_hi_q, t_hi_d;
    logic [HW-1:0] s_hi_q, s_hi_d;
    logic          v1_q, v1_d;
    logic [N:0]    sum_q, sum_d;
    logic          v2_q, v2_d;
    logic          adv1_s, adv2_s;
    logic [LO:0]   lo_full_s;
    logic [HW:0]   hi_full_s;

    // Pipeline advance conditions: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv2_s   = !v2_q || out_ready;
        adv1_s   = !v1_q || adv2_s;
        in_ready = adv1_s;
    end

    // Stage 1: low-slice add and capture of the upper slices.
    always_comb begin
        lo_full_s = {1'b0, in_t[LO-1:0]} + {1'b0, in_s[LO-1:0]};
        lo_sum_d  = lo_sum_q;
        c1_d      = c1_q;
        t_hi_d    = t_hi_q;
        s_hi_d    = s_hi_q;
        v1_d      = v1_q;
        if (adv1_s) begin
            lo_sum_d = lo_full_s[LO-1:0];
            c1_d     = lo_full_s[LO];
            t_hi_d   = in_t[N-1:LO];
            s_hi_d   = in_s[N-1:LO];
            v1_d     = in_valid;
        end else begin
            v1_d     = v1_q;
        end
    end

    // Stage 2: upper-slice add with the stage-1 carry, concatenated with the low sum.
    always_comb begin
        hi_full_s = {1'b0, t_hi_q} + {1'b0, s_hi_q} + {{HW{1'b0}}, c1_q};
        sum_d     = sum_q;
        v2_d      = v2_q;
        if (adv2_s) begin
            sum_d = {hi_full_s, lo_sum_q};
            v2_d  = v1_q;
        end else begin
            v2_d  = v2_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_sum_q <= {LO{1'b0}};
            c1_q     <= 1'b0;
            t_hi_q   <= {HW{1'b0}};
            s_hi_q   <= {HW{1'b0}};
            v1_q     <= 1'b0;
            sum_q    <= {(N+1){1'b0}};
            v2_q     <= 1'b0;
        end else begin
            lo_sum_q <= lo_sum_d;
            c1_q     <= c1_d;
            t_hi_q   <= t_hi_d;
            s_hi_q   <= s_hi_d;
            v1_q     <= v1_d;
            sum_q    <= sum_d;
            v2_q     <= v2_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_valid = v2_q;

`ifdef CS_FINAL_ADD_STICKY_EN
    logic sticky_q, sticky_d;

    function automatic logic sticky_of(input logic [N:0] v);
        sticky_of = |v[STK-1:0];
    endfunction

    // Sticky follows the stage-2 sum update so it stays aligned with out_sum.
    always_comb begin
        sticky_d = sticky_q;
        if (adv2_s) begin
            sticky_d = sticky_of(sum_d);
        end else begin
            sticky_d = sticky_q;
        end
    end

    // Sticky register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign out_sticky = sticky_q;
`else
    assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_cs_final_add.sv
// Scoreboard bench for cs_final_add: driver pushes expected results, monitor pops on output transfer.
module tb_cs_final_add;

    localparam int N = 14;
`ifdef CS_FINAL_ADD_STICKY_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] in_t, in_s;
    logic         in_valid;
    logic         in_ready;
    logic [N:0]   out_sum;
    logic         out_sticky;
    logic         out_valid;
    logic         out_ready;

    typedef struct {
        logic [N:0] sum;
        logic       stk;
        bit         chk_lat;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    cs_final_add #(.N(14), .LO(7), .STK(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_t      (in_t),
        .in_s      (in_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_sticky(out_sticky),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one word, hold until accepted, push its expected result.
    task automatic send(input logic [N-1:0] t, input logic [N-1:0] s,
                        input logic [N:0] esum, input logic estk, input bit lat);
        exp_t e;
        bit   done;
        done     = 1'b0;
        in_t     = t;
        in_s     = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.sum     = esum;
                e.stk     = estk & STK_EN;
                e.chk_lat = lat;
                e.cyc     = cyc;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: compare each output transfer against the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {17'd0, out_sum}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_sum", {17'd0, out_sum}, {17'd0, e.sum});
                    check("out_sticky", {31'd0, out_sticky}, {31'd0, e.stk});
                    if (e.chk_lat) check("latency", cyc - e.cyc, 32'd2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_t      = '0;
        in_s      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {17'd0, out_sum}, 32'd0);
        check("rst_out_sticky", {31'd0, out_sticky}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed single words.
        send(14'h0001, 14'h007F, 15'h0080, 1'b0, 1'b1);
        send(14'h3FFF, 14'h3FFF, 15'h7FFE, 1'b1, 1'b1);
        send(14'h0003, 14'h0000, 15'h0003, 1'b1, 1'b1);
        drain();

        // Back-to-back stream of eight words.
        send(14'h0000, 14'h0000, 15'h0000, 1'b0, 1'b1);
        send(14'h0010, 14'h0020, 15'h0030, 1'b0, 1'b1);
        send(14'h007F, 14'h007F, 15'h00FE, 1'b1, 1'b1);
        send(14'h2000, 14'h2000, 15'h4000, 1'b0, 1'b1);
        send(14'h1234, 14'h0101, 15'h1335, 1'b1, 1'b1);
        send(14'h3F80, 14'h0080, 15'h4000, 1'b0, 1'b1);
        send(14'h0155, 14'h02AA, 15'h03FF, 1'b1, 1'b1);
        send(14'h3000, 14'h0FFF, 15'h3FFF, 1'b1, 1'b1);
        drain();

        // Two words then a five-cycle output stall.
        out_ready = 1'b0;
        send(14'h0100, 14'h0200, 15'h0300, 1'b0, 1'b0);
        send(14'h0005, 14'h0006, 15'h000B, 1'b1, 1'b0);
        in_t     = 14'h0777;
        in_s     = 14'h0111;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_out_sum", {17'd0, out_sum}, 32'h0300);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with a word in flight, then a fresh word.
        send(14'h0AAA, 14'h0555, 15'h0FFF, 1'b1, 1'b0);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
            @(posedge clk); #1;
        end
        send(14'h0010, 14'h0008, 15'h0018, 1'b1, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cs_final_add.md
CS_FINAL_ADD -- requirements
Module: cs_final_add

Interface
REQ-001 Parameter N, default 14, SHALL set the width of each carry-save input word.
REQ-002 Parameter LO, default 7, SHALL set the width of the low slice added in stage 1 (1 <= LO < N).
REQ-003 Parameter STK, default 4, SHALL set how many LSBs of the sum fold into the sticky bit (1 <= STK <= N).
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 in_t  input  N  SHALL carry the carry-save transfer word from the 4:2 compressor stage.
REQ-007 in_s  input  N  SHALL carry the carry-save sum word from the 4:2 compressor stage.
REQ-008 in_valid  input  1  SHALL mark in_t/in_s as valid.
REQ-009 in_ready  output  1  SHALL mark that the block accepts a word this cycle.
REQ-010 out_sum  output  N+1  SHALL be the binary value in_t + in_s, including carry-out.
REQ-011 out_sticky  output  1  SHALL be the OR of out_sum[STK-1:0].
REQ-012 out_valid  output  1  SHALL mark out_sum/out_sticky as valid.
REQ-013 out_ready  input  1  SHALL mark that the consumer accepts the output this cycle.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 Stage 1 SHALL register: in_t[LO-1:0] + in_s[LO-1:0] (LO bits); carry c1; in_t[N-1:LO] and in_s[N-1:LO]; valid bit v1.
REQ-016 Stage 2 SHALL register: out_sum[N:LO] = t_hi + s_hi + c1; out_sum[LO-1:0] = stage-1 low sum; out_sticky; v2 driving out_valid.
REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid with out_ready held high; throughput SHALL be 1 word/cycle.
REQ-018 Stage 2 SHALL advance when !v2 || out_ready; stage 1 SHALL advance when !v1 || stage 2 advances.
REQ-019 in_ready SHALL equal !v1 || (!v2 || out_ready), purely combinational; it SHALL NOT depend on in_valid.
REQ-020 Stall: with out_valid=1 and out_ready=0, out_sum/out_sticky/out_valid SHALL hold unchanged; stage 1 SHALL hold if full.
REQ-021 Full stall (v1=v2=1, out_ready=0) SHALL drive in_ready=0; no word SHALL be lost or duplicated.
REQ-022 Simultaneous drain and fill (both stages full, out_ready=1, in_valid=1) SHALL shift both stages in the same cycle.
REQ-023 Arithmetic SHALL be unsigned; the maximum input pair (2^N-1, 2^N-1) SHALL yield out_sum = 2^(N+1)-2 without overflow.
REQ-024 Bubbles (in_valid=0 while advancing) SHALL clear the stage valid bit; data registers of an empty stage are don't-care.

Reset
REQ-025 While reset=1 at a clock edge: v1=0, v2=0, out_valid=0, out_sum=0, out_sticky=0.
REQ-026 in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight words; none SHALL appear at the output afterwards.

Configuration
REQ-028 Macro CS_FINAL_ADD_STICKY_EN defined: out_sticky SHALL be computed per REQ-011 and registered in stage 2.
REQ-029 Macro CS_FINAL_ADD_STICKY_EN undefined: out_sticky SHALL be constant 0 and no sticky logic SHALL be synthesised; all other behaviour unchanged.

Verification (N=14, LO=7, STK=4, macro defined unless stated)
REQ-030 in_t=0x0001, in_s=0x007F, out_ready=1 -> 2 cycles later out_sum=0x00080 (low-slice carry into bit 7), out_sticky=0.
REQ-031 in_t=0x3FFF, in_s=0x3FFF -> out_sum=0x7FFE, out_sticky=1.
REQ-032 Back-to-back stream of 8 words, out_ready=1 -> 8 outputs on consecutive cycles, in order, each equal to in_t+in_s.
REQ-033 Two words accepted, then out_ready=0 for 5 cycles -> in_ready=0 once both stages full, first output held stable; on out_ready=1 both words emerge in order.
REQ-034 Word accepted, reset pulsed 1 cycle later -> out_valid stays 0 after reset; next word 0x0010+0x0008 -> out_sum=0x00018, out_sticky=1 (bit 3 set).
REQ-035 Macro undefined, in_t=0x0003, in_s=0x0000 -> out_sum=0x00003, out_sticky=0.
